// File: rtl/mc_axi_traffic_gen.sv
// mc_axi_traffic_gen: AXI4 initiator that writes a seeded incrementing pattern,
// reads it back, and counts data/response mismatches.
module mc_axi_traffic_gen #(
  parameter int AXI_ID_WIDTH = 4,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int BURST_LEN = 4,
  parameter int NUM_BURSTS = 2,
  parameter logic [AXI_ID_WIDTH-1:0] TXN_ID = '0
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic                        start_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   base_addr_i,
  input  logic [31:0]                 seed_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        pass_o,
  output logic [15:0]                 err_cnt_o,
  output logic                        axi_awvalid_o,
  input  logic                        axi_awready_i,
  output logic [AXI_ID_WIDTH-1:0]     axi_awid_o,
  output logic [AXI_ADDR_WIDTH-1:0]   axi_awaddr_o,
  output logic [2:0]                  axi_awsize_o,
  output logic [7:0]                  axi_awlen_o,
  output logic [1:0]                  axi_awburst_o,
  output logic                        axi_wvalid_o,
  input  logic                        axi_wready_i,
  output logic [AXI_DATA_WIDTH-1:0]   axi_wdata_o,
  output logic [AXI_DATA_WIDTH/8-1:0] axi_wstrb_o,
  output logic                        axi_wlast_o,
  input  logic                        axi_bvalid_i,
  input  logic [AXI_ID_WIDTH-1:0]     axi_bid_i,
  input  logic [1:0]                  axi_bresp_i,
  output logic                        axi_bready_o,
  output logic                        axi_arvalid_o,
  input  logic                        axi_arready_i,
  output logic [AXI_ID_WIDTH-1:0]     axi_arid_o,
  output logic [AXI_ADDR_WIDTH-1:0]   axi_araddr_o,
  output logic [2:0]                  axi_arsize_o,
  output logic [7:0]                  axi_arlen_o,
  output logic [1:0]                  axi_arburst_o,
  input  logic                        axi_rvalid_i,
  input  logic [AXI_ID_WIDTH-1:0]     axi_rid_i,
  input  logic [AXI_DATA_WIDTH-1:0]   axi_rdata_i,
  input  logic [1:0]                  axi_rresp_i,
  input  logic                        axi_rlast_i,
  output logic                        axi_rready_o
);
  typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD, RD_DATA, DONE} state_t;
  localparam logic [8:0] LAST_BEAT = 9'(BURST_LEN - 1);
  localparam logic [15:0] LAST_BURST = 16'(NUM_BURSTS - 1);
  localparam logic [AXI_ADDR_WIDTH-1:0] STRIDE = AXI_ADDR_WIDTH'(BURST_LEN * 4);
  state_t state, state_nx;
  logic [AXI_ADDR_WIDTH-1:0] addr, base;
  logic [AXI_DATA_WIDTH-1:0] data, seed;
  logic [8:0] beat;
  logic [15:0] burst, err_cnt;
  logic aw_done, w_done;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic beat_last, burst_last, wr_end, b_err, r_err, start_ok;
  assign aw_hs = axi_awvalid_o && axi_awready_i;
  assign w_hs = axi_wvalid_o && axi_wready_i;
  assign b_hs = axi_bvalid_i && axi_bready_o;
  assign ar_hs = axi_arvalid_o && axi_arready_i;
  assign r_hs = axi_rvalid_i && axi_rready_o;
  assign beat_last = beat == LAST_BEAT;
  assign burst_last = burst == LAST_BURST;
  assign start_ok = start_i && (state == IDLE || state == DONE);
  // AW and the final W beat may complete in either order
  assign wr_end = (aw_done || aw_hs) && (w_done || (w_hs && beat_last));
  assign b_err = axi_bresp_i != 2'b00 || axi_bid_i != TXN_ID;
  assign r_err = axi_rdata_i != data || axi_rresp_i != 2'b00 || axi_rid_i != TXN_ID ||
                 axi_rlast_i != beat_last;
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: state_nx = start_i ? WR : state;
      WR:         state_nx = wr_end ? WR_RESP : WR;
      WR_RESP:    state_nx = b_hs ? (burst_last ? RD : WR) : WR_RESP;
      RD:         state_nx = ar_hs ? RD_DATA : RD;
      RD_DATA:    state_nx = (r_hs && beat_last) ? (burst_last ? DONE : RD) : RD_DATA;
      default:    state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      addr <= '0;
      base <= '0;
      data <= '0;
      seed <= '0;
      beat <= '0;
      burst <= '0;
      err_cnt <= '0;
      aw_done <= 1'b0;
      w_done <= 1'b0;
    end else begin
      if (start_ok) begin
        addr <= base_addr_i;
        base <= base_addr_i;
        data <= seed_i;
        seed <= seed_i;
        beat <= '0;
        burst <= '0;
        err_cnt <= '0;
        aw_done <= 1'b0;
        w_done <= 1'b0;
      end
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs && beat_last) w_done <= 1'b1;
      if (w_hs || r_hs) begin
        data <= data + 1'b1;
        beat <= beat_last ? '0 : beat + 1'b1;
      end
      if (state == WR && wr_end) begin
        aw_done <= 1'b0;
        w_done <= 1'b0;
      end
      if (b_hs || (r_hs && beat_last)) begin
        burst <= burst_last ? '0 : burst + 1'b1;
        addr <= burst_last ? base : addr + STRIDE;
      end
      // read phase regenerates the pattern from the stored seed
      if (b_hs && burst_last) data <= seed;
      if ((b_hs && b_err) || (r_hs && r_err))
        err_cnt <= (err_cnt == 16'hFFFF) ? err_cnt : err_cnt + 1'b1;
    end
  assign busy_o = state != IDLE && state != DONE;
  assign done_o = state == DONE;
  assign pass_o = done_o && err_cnt == 16'h0000;
  assign err_cnt_o = err_cnt;
  assign axi_awvalid_o = state == WR && !aw_done;
  assign axi_awid_o = TXN_ID;
  assign axi_awaddr_o = addr;
  assign axi_awsize_o = 3'b010;
  assign axi_awlen_o = 8'(BURST_LEN - 1);
  assign axi_awburst_o = 2'b01;
  assign axi_wvalid_o = state == WR && !w_done;
  assign axi_wdata_o = data;
  assign axi_wstrb_o = '1;
  assign axi_wlast_o = axi_wvalid_o && beat_last;
  assign axi_bready_o = state == WR_RESP;
  assign axi_arvalid_o = state == RD;
  assign axi_arid_o = TXN_ID;
  assign axi_araddr_o = addr;
  assign axi_arsize_o = 3'b010;
  assign axi_arlen_o = 8'(BURST_LEN - 1);
  assign axi_arburst_o = 2'b01;
  assign axi_rready_o = state == RD_DATA;
endmodule

// File: tb/tb_mc_axi_traffic_gen.sv
// tb_mc_axi_traffic_gen: directed bench with a memory-backed AXI responder whose
// delays, stalls and injected errors are set per scenario.
module tb_mc_axi_traffic_gen;
  localparam int BL = 4;
  logic clk = 0, rst_n, start;
  logic [31:0] base_addr, seed;
  logic busy, done, pass;
  logic [15:0] err_cnt;
  logic awvalid, awready, wvalid, wready, wlast, bvalid, bready, arvalid, arready;
  logic rvalid, rlast, rready;
  logic [3:0] awid, arid, wstrb;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [2:0] awsize, arsize;
  logic [7:0] awlen, arlen;
  logic [1:0] awburst, arburst, bresp, rresp;
  int checks = 0, errors = 0;
  int aw_delay, ar_delay, corrupt_k, bresp_b, rresp_k;
  bit r_stall;
  logic [31:0] exp_base, exp_seed, a_tmp;
  int aw_n, wk, ar_n, rk, bn, done_rises, unstable;
  logic [31:0] awq[$], wq[$], arq[$];
  logic [1:0] bq[$];
  bit b_hs, r_hs, aw_hs_f, ar_hs_f, gap, p_aw_stall, p_ar_stall, prev_done;
  int aw_wait, ar_wait, rbeat;
  logic [31:0] p_awaddr, p_araddr;
  logic [31:0] mem [0:1023];

  mc_axi_traffic_gen #(.AXI_ID_WIDTH(4), .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32),
    .BURST_LEN(BL), .NUM_BURSTS(2), .TXN_ID(4'h0)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .base_addr_i(base_addr), .seed_i(seed),
    .busy_o(busy), .done_o(done), .pass_o(pass), .err_cnt_o(err_cnt),
    .axi_awvalid_o(awvalid), .axi_awready_i(awready), .axi_awid_o(awid), .axi_awaddr_o(awaddr),
    .axi_awsize_o(awsize), .axi_awlen_o(awlen), .axi_awburst_o(awburst),
    .axi_wvalid_o(wvalid), .axi_wready_i(wready), .axi_wdata_o(wdata), .axi_wstrb_o(wstrb),
    .axi_wlast_o(wlast), .axi_bvalid_i(bvalid), .axi_bid_i(4'h0), .axi_bresp_i(bresp),
    .axi_bready_o(bready), .axi_arvalid_o(arvalid), .axi_arready_i(arready), .axi_arid_o(arid),
    .axi_araddr_o(araddr), .axi_arsize_o(arsize), .axi_arlen_o(arlen), .axi_arburst_o(arburst),
    .axi_rvalid_i(rvalid), .axi_rid_i(4'h0), .axi_rdata_i(rdata), .axi_rresp_i(rresp),
    .axi_rlast_i(rlast), .axi_rready_o(rready));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    if (rst_n) begin
      if (p_aw_stall && (!awvalid || awaddr !== p_awaddr)) unstable++;
      if (p_ar_stall && (!arvalid || araddr !== p_araddr)) unstable++;
      p_aw_stall = awvalid && !awready;
      p_ar_stall = arvalid && !arready;
      p_awaddr = awaddr;
      p_araddr = araddr;
      if (awvalid && awready) begin
        check("aw_addr", awaddr, exp_base + 32'(aw_n * 16));
        check("aw_fields", {awid, awsize, awlen, awburst}, {4'h0, 3'b010, 8'd3, 2'b01});
        aw_n++;
        awq.push_back(awaddr);
        aw_hs_f = 1;
      end
      if (wvalid && wready) begin
        check("w_data", wdata, exp_seed + 32'(wk));
        check("w_last", wlast, (wk % BL) == BL - 1);
        wq.push_back(wdata);
        wk++;
      end
      if (bvalid && bready) b_hs = 1;
      if (arvalid && arready) begin
        check("ar_addr", araddr, exp_base + 32'(ar_n * 16));
        ar_n++;
        arq.push_back(araddr);
        ar_hs_f = 1;
      end
      if (rvalid && rready) begin
        r_hs = 1;
        rk++;
      end
      if (done && !prev_done) done_rises++;
      prev_done = done;
    end else begin
      p_aw_stall = 0;
      p_ar_stall = 0;
      prev_done = 0;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      awq.delete(); wq.delete(); arq.delete(); bq.delete();
      b_hs = 0; r_hs = 0; aw_hs_f = 0; ar_hs_f = 0; gap = 0;
      aw_wait = 0; ar_wait = 0; rbeat = 0;
      awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
      bresp = 0; rresp = 0; rdata = 0; rlast = 0;
    end else begin
      if (aw_hs_f) aw_wait = 0;
      else if (awvalid && aw_wait < aw_delay) aw_wait++;
      awready = aw_wait >= aw_delay;
      if (ar_hs_f) ar_wait = 0;
      else if (arvalid && ar_wait < ar_delay) ar_wait++;
      arready = ar_wait >= ar_delay;
      wready = 1;
      if (b_hs) void'(bq.pop_front());
      while (awq.size() > 0 && wq.size() >= BL) begin
        a_tmp = awq.pop_front();
        for (int i = 0; i < BL; i++) mem[(int'(a_tmp[11:2]) + i) & 1023] = wq.pop_front();
        bq.push_back(bn == bresp_b ? 2'b10 : 2'b00);
        bn++;
      end
      bvalid = bq.size() > 0;
      bresp = bvalid ? bq[0] : 2'b00;
      if (r_hs) begin
        rbeat++;
        gap = r_stall;
        if (rbeat == BL) begin
          rbeat = 0;
          void'(arq.pop_front());
        end
      end
      rvalid = arq.size() > 0 && !gap;
      gap = 0;
      if (arq.size() > 0) begin
        a_tmp = arq[0];
        rdata = (rk == corrupt_k) ? 32'h0 : mem[(int'(a_tmp[11:2]) + rbeat) & 1023];
        rresp = (rk == rresp_k) ? 2'b10 : 2'b00;
        rlast = rbeat == BL - 1;
      end
      b_hs = 0; r_hs = 0; aw_hs_f = 0; ar_hs_f = 0;
    end
  end

  task automatic clear_counts(input logic [31:0] b, input logic [31:0] s);
    exp_base = b; exp_seed = s;
    aw_n = 0; wk = 0; ar_n = 0; rk = 0; bn = 0; done_rises = 0;
  endtask

  task automatic run(input string tag, input logic [31:0] b, input logic [31:0] s,
                     input int awd, input int ard, input bit stall, input int ck,
                     input int bb, input int rrk, input bit mid, input logic [15:0] exp_err);
    aw_delay = awd; ar_delay = ard; r_stall = stall;
    corrupt_k = ck; bresp_b = bb; rresp_k = rrk;
    clear_counts(b, s);
    @(negedge clk);
    base_addr = b; seed = s; start = 1;
    @(posedge clk);
    #1;
    check({tag, "_start_busy"}, {busy, wvalid, awvalid}, 3'b111);
    @(negedge clk);
    start = 0;
    if (mid) begin
      @(negedge clk);
      start = 1;
      @(negedge clk);
      start = 0;
    end
    for (int i = 0; i < 2000 && !done; i++) @(negedge clk);
    check({tag, "_done"}, done, 1);
    check({tag, "_busy_off"}, busy, 0);
    check({tag, "_err_cnt"}, err_cnt, exp_err);
    check({tag, "_pass"}, pass, exp_err == 0);
    check({tag, "_aw_count"}, aw_n, 2);
    check({tag, "_ar_count"}, ar_n, 2);
    check({tag, "_w_beats"}, wk, 8);
    check({tag, "_r_beats"}, rk, 8);
    repeat (3) @(negedge clk);
    check({tag, "_done_hold"}, {done, busy}, 2'b10);
    check({tag, "_done_rises"}, done_rises, 1);
  endtask

  initial begin
    rst_n = 0; start = 0; base_addr = 0; seed = 0;
    aw_delay = 0; ar_delay = 0; r_stall = 0; corrupt_k = -1; bresp_b = -1; rresp_k = -1;
    unstable = 0;
    clear_counts(0, 0);
    repeat (3) @(negedge clk);
    check("rst_status", {busy, done, pass, err_cnt}, 19'h0);
    check("rst_valids", {awvalid, wvalid, wlast, bready, arvalid, rready}, 6'h0);
    check("rst_addr_data", {awaddr, araddr, wdata}, 96'h0);
    rst_n = 1;
    run("basic", 32'h100, 32'hFFFF1111, 0, 0, 0, -1, -1, -1, 0, 16'd0);
    run("bp", 32'h100, 32'hA5A50000, 5, 3, 1, -1, -1, -1, 0, 16'd0);
    check("bp_stable", unstable, 0);
    run("corrupt", 32'h100, 32'hFFFF1111, 0, 0, 0, 2, -1, -1, 0, 16'd1);
    run("badresp", 32'h100, 32'h00000010, 0, 0, 0, -1, 0, 5, 0, 16'd2);
    run("mid_start", 32'h180, 32'h7FFFFFFE, 0, 0, 0, -1, -1, -1, 1, 16'd0);
    aw_delay = 0; ar_delay = 0; r_stall = 0; corrupt_k = -1; bresp_b = -1; rresp_k = -1;
    clear_counts(32'h100, 32'h12345678);
    @(negedge clk);
    base_addr = 32'h100; seed = 32'h12345678; start = 1;
    @(negedge clk);
    start = 0;
    for (int i = 0; i < 50 && wk < 2; i++) @(negedge clk);
    check("rst_mid_beat", wk, 2);
    #2 rst_n = 0;
    #1;
    check("rst_mid_valids", {awvalid, wvalid, wlast, arvalid, bready, rready}, 6'h0);
    check("rst_mid_status", {busy, done, pass}, 3'b000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    run("after_rst", 32'h200, 32'h0BADF00D, 0, 0, 0, -1, -1, -1, 0, 16'd0);
    check("final_stable", unstable, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
